// File: rtl/timer_pkg.sv
// Shared BCD types and helpers for the game countdown timers.
// bcd_add_sat exists only when TIMER_TIME_BONUS_EN is defined.
package timer_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef struct packed {
    bcd_digit_t tens;
    bcd_digit_t ones;
  } bcd2_t;

  localparam bcd_digit_t BCD_MAX            = 4'd9;
  localparam bcd_digit_t DEFAULT_START_TENS = 4'd6;
  localparam bcd_digit_t DEFAULT_START_ONES = 4'd0;

  // Two-digit BCD decrement; 00 maps to itself so a caller can never wrap.
  function automatic bcd2_t bcd_dec2(input bcd2_t v);
    bcd2_t r;
    r = v;
    if (v.ones != 4'd0) begin
      r.ones = v.ones - 4'd1;
    end else if (v.tens != 4'd0) begin
      r.ones = BCD_MAX;
      r.tens = v.tens - 4'd1;
    end
    return r;
  endfunction

  function automatic logic [6:0] bcd2_to_bin(input bcd2_t v);
    return ({3'b000, v.tens} * 7'd10) + {3'b000, v.ones};
  endfunction

`ifdef TIMER_TIME_BONUS_EN
  // Adds a single BCD digit with carry into tens, saturating at 99.
  function automatic bcd2_t bcd_add_sat(input bcd2_t v, input bcd_digit_t a);
    logic [4:0] ones_sum;
    logic [4:0] tens_sum;
    bcd2_t      r;
    ones_sum = {1'b0, v.ones} + {1'b0, a};
    tens_sum = {1'b0, v.tens};
    if (ones_sum > 5'd9) begin
      ones_sum = ones_sum - 5'd10;
      tens_sum = tens_sum + 5'd1;
    end
    if (tens_sum > 5'd9) begin
      r.tens = BCD_MAX;
      r.ones = BCD_MAX;
    end else begin
      r.tens = tens_sum[3:0];
      r.ones = ones_sum[3:0];
    end
    return r;
  endfunction
`endif

endpackage

// File: rtl/level_countdown_timer_if.sv
// Control/status bundle between the level controller, the timer-end checker and the timer.
// The bonus signals are present only when TIMER_TIME_BONUS_EN is defined.
interface level_countdown_timer_if;
  import timer_pkg::*;

  logic       start_level;
  logic       enable_timer;
  bcd_digit_t ones;
  bcd_digit_t tens;
  logic       one_sec;
  logic       low_time;
`ifdef TIMER_TIME_BONUS_EN
  logic       add_time;
  bcd_digit_t add_ones;

  modport master (
    output start_level, enable_timer, add_time, add_ones,
    input  ones, tens, one_sec, low_time
  );

  modport slave (
    input  start_level, enable_timer, add_time, add_ones,
    output ones, tens, one_sec, low_time
  );
`else
  modport master (
    output start_level, enable_timer,
    input  ones, tens, one_sec, low_time
  );

  modport slave (
    input  start_level, enable_timer,
    output ones, tens, one_sec, low_time
  );
`endif

endinterface

// File: rtl/sec_tick_gen.sv
// Prescaler producing a one-cycle tick every TICKS_PER_SEC enabled cycles.
// clear has priority over enable and returns the count to 0.
module sec_tick_gen #(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic clk,
  input  logic resetN,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int            CW   = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

  logic [CW-1:0] r_count;

  assign tick = enable && !clear && (r_count == LAST);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= tick ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/level_countdown_timer.sv
// Per-level BCD seconds countdown: reload on start_level, decrement once per second, hold at 00.
// Optional time bonus (add_time/add_ones) enabled by defining TIMER_TIME_BONUS_EN.
module level_countdown_timer
  import timer_pkg::*;
#(
  parameter int         TICKS_PER_SEC = 50_000_000,
  parameter bcd_digit_t START_TENS    = DEFAULT_START_TENS,
  parameter bcd_digit_t START_ONES    = DEFAULT_START_ONES,
  parameter int         LOW_TIME_SEC  = 10
) (
  input  logic                   clk,
  input  logic                   resetN,
  level_countdown_timer_if.slave bus
);

  localparam logic [6:0] LOW_LIMIT = 7'(LOW_TIME_SEC);

  bcd2_t r_value;
  logic  r_one_sec;

  logic  w_tick;
  logic  w_zero;
  logic  w_clear;
  logic  w_count_en;
  logic  w_update;
  bcd2_t w_start;
  bcd2_t w_dec;
  bcd2_t w_next;
  logic [6:0] w_seconds;

  assign w_start.tens = START_TENS;
  assign w_start.ones = START_ONES;

  // An expired level keeps the prescaler parked at 0 until the next reload.
  assign w_zero     = (r_value == '0);
  assign w_clear    = bus.start_level || w_zero;
  assign w_count_en = bus.enable_timer && !w_zero;

  sec_tick_gen #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_tick (
    .clk   (clk),
    .resetN(resetN),
    .clear (w_clear),
    .enable(w_count_en),
    .tick  (w_tick)
  );

  assign w_dec = bcd_dec2(r_value);

`ifdef TIMER_TIME_BONUS_EN
  logic  w_bonus_ok;
  bcd2_t w_base;

  // Bonus is applied on top of this cycle's decrement; 00 cannot be revived.
  assign w_bonus_ok = bus.add_time && (bus.add_ones != 4'd0) &&
                      (bus.add_ones <= BCD_MAX) && !w_zero;
  assign w_base     = w_tick ? w_dec : r_value;
  assign w_next     = w_bonus_ok ? bcd_add_sat(w_base, bus.add_ones) : w_base;
  assign w_update   = w_tick || w_bonus_ok;
`else
  assign w_next     = w_dec;
  assign w_update   = w_tick;
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_value   <= w_start;
      r_one_sec <= 1'b0;
    end else if (bus.start_level) begin
      r_value   <= w_start;
      r_one_sec <= 1'b0;
    end else begin
      r_one_sec <= w_tick;
      if (w_update) begin
        r_value <= w_next;
      end
    end
  end

  assign w_seconds    = bcd2_to_bin(r_value);
  assign bus.low_time = !w_zero && (w_seconds <= LOW_LIMIT);
  assign bus.tens     = r_value.tens;
  assign bus.ones     = r_value.ones;
  assign bus.one_sec  = r_one_sec;

endmodule

// File: tb/tb_level_countdown_timer.sv
// Directed bench for level_countdown_timer with TICKS_PER_SEC=4 and starts of 60, 11 and 12.
// Bonus vectors run only when TIMER_TIME_BONUS_EN is defined.
module tb_level_countdown_timer;
  import timer_pkg::*;

  localparam int TPS = 4;

  logic clk    = 1'b0;
  logic resetN = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  level_countdown_timer_if bus60 ();
  level_countdown_timer_if bus11 ();
  level_countdown_timer_if bus12 ();

  level_countdown_timer #(.TICKS_PER_SEC(TPS), .START_TENS(4'd6), .START_ONES(4'd0),
                          .LOW_TIME_SEC(10))
    u_dut60 (.clk(clk), .resetN(resetN), .bus(bus60));
  level_countdown_timer #(.TICKS_PER_SEC(TPS), .START_TENS(4'd1), .START_ONES(4'd1),
                          .LOW_TIME_SEC(10))
    u_dut11 (.clk(clk), .resetN(resetN), .bus(bus11));
  level_countdown_timer #(.TICKS_PER_SEC(TPS), .START_TENS(4'd1), .START_ONES(4'd2),
                          .LOW_TIME_SEC(10))
    u_dut12 (.clk(clk), .resetN(resetN), .bus(bus12));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("check %s ok (%0h)", tag, got);
    end
  endtask

  // Advance n clocks; returns on the falling edge so samples sit mid-cycle.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  logic [7:0] seq11 [11];
  logic [7:0] seq12 [12];
  logic       low12 [12];

  initial begin
    seq11 = '{8'h10, 8'h09, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
    seq12 = '{8'h11, 8'h10, 8'h09, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
    low12 = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    bus60.start_level = 1'b0; bus60.enable_timer = 1'b0;
    bus11.start_level = 1'b0; bus11.enable_timer = 1'b0;
    bus12.start_level = 1'b0; bus12.enable_timer = 1'b0;
`ifdef TIMER_TIME_BONUS_EN
    bus60.add_time = 1'b0; bus60.add_ones = 4'd0;
    bus11.add_time = 1'b0; bus11.add_ones = 4'd0;
    bus12.add_time = 1'b0; bus12.add_ones = 4'd0;
`endif

    // Reset state
    step(2);
    check_val("rst_val60", {bus60.tens, bus60.ones}, 8'h60);
    check_val("rst_osec60", bus60.one_sec, 0);
    check_val("rst_val11", {bus11.tens, bus11.ones}, 8'h11);
    check_val("rst_low12", bus12.low_time, 0);
    resetN = 1'b1;
    step(1);
    check_val("idle_val60", {bus60.tens, bus60.ones}, 8'h60);

    // First two decrements after load
    bus60.start_level = 1'b1; bus60.enable_timer = 1'b1;
    step(1);
    bus60.start_level = 1'b0;
    check_val("load_val60", {bus60.tens, bus60.ones}, 8'h60);
    step(3);
    check_val("pre_tick_val", {bus60.tens, bus60.ones}, 8'h60);
    check_val("pre_tick_osec", bus60.one_sec, 0);
    step(1);
    check_val("dec59_val", {bus60.tens, bus60.ones}, 8'h59);
    check_val("dec59_osec", bus60.one_sec, 1);
    step(1);
    check_val("osec_width", bus60.one_sec, 0);
    step(3);
    check_val("dec58_val", {bus60.tens, bus60.ones}, 8'h58);
    check_val("dec58_osec", bus60.one_sec, 1);

    // Pause two cycles into a second
    step(2);
    check_val("pause_pre_cnt", u_dut60.u_tick.r_count, 2);
    bus60.enable_timer = 1'b0;
    step(10);
    check_val("pause_val", {bus60.tens, bus60.ones}, 8'h58);
    check_val("pause_cnt", u_dut60.u_tick.r_count, 2);
    check_val("pause_osec", bus60.one_sec, 0);
    bus60.enable_timer = 1'b1;
    step(1);
    check_val("resume_hold", {bus60.tens, bus60.ones}, 8'h58);
    step(1);
    check_val("resume_dec", {bus60.tens, bus60.ones}, 8'h57);
    check_val("resume_osec", bus60.one_sec, 1);

    // start_level coincident with a tick at 35
    step(88);
    check_val("reach35", {bus60.tens, bus60.ones}, 8'h35);
    step(3);
    check_val("tick_pending_cnt", u_dut60.u_tick.r_count, 3);
    bus60.start_level = 1'b1;
    step(1);
    bus60.start_level = 1'b0;
    check_val("start_vs_tick_val", {bus60.tens, bus60.ones}, 8'h60);
    check_val("start_vs_tick_osec", bus60.one_sec, 0);
    check_val("start_vs_tick_cnt", u_dut60.u_tick.r_count, 0);

    // Asynchronous reset mid-count
    step(4);
    check_val("pre_areset_val", {bus60.tens, bus60.ones}, 8'h59);
    #2 resetN = 1'b0;
    #1;
    check_val("areset_val", {bus60.tens, bus60.ones}, 8'h60);
    check_val("areset_osec", bus60.one_sec, 0);
    bus60.enable_timer = 1'b0;
    @(negedge clk);
    resetN = 1'b1;

    // Borrow sequence and hold at 00
    bus11.start_level = 1'b1; bus11.enable_timer = 1'b1;
    step(1);
    bus11.start_level = 1'b0;
    check_val("load_val11", {bus11.tens, bus11.ones}, 8'h11);
    for (int i = 0; i < 11; i++) begin
      step(4);
      check_val($sformatf("seq11_%0d_val", i), {bus11.tens, bus11.ones}, seq11[i]);
      check_val($sformatf("seq11_%0d_osec", i), bus11.one_sec, 1);
    end
    for (int i = 0; i < 20; i++) begin
      step(1);
      check_val($sformatf("hold00_%0d_val", i), {bus11.tens, bus11.ones}, 8'h00);
      check_val($sformatf("hold00_%0d_osec", i), bus11.one_sec, 0);
      check_val($sformatf("hold00_%0d_cnt", i), u_dut11.u_tick.r_count, 0);
    end

    // low_time threshold
    bus12.start_level = 1'b1; bus12.enable_timer = 1'b1;
    step(1);
    bus12.start_level = 1'b0;
    check_val("load_val12", {bus12.tens, bus12.ones}, 8'h12);
    check_val("low_at12", bus12.low_time, 0);
    for (int i = 0; i < 12; i++) begin
      step(4);
      check_val($sformatf("seq12_%0d_val", i), {bus12.tens, bus12.ones}, seq12[i]);
      check_val($sformatf("seq12_%0d_low", i), bus12.low_time, low12[i]);
    end

`ifdef TIMER_TIME_BONUS_EN
    // Bonus adds with the count paused, then saturation
    bus60.start_level = 1'b1; bus60.enable_timer = 1'b0;
    step(1);
    bus60.start_level = 1'b0;
    bus60.add_time = 1'b1; bus60.add_ones = 4'd9; step(1);
    check_val("bonus_69", {bus60.tens, bus60.ones}, 8'h69);
    step(1);
    check_val("bonus_78", {bus60.tens, bus60.ones}, 8'h78);
    step(1);
    check_val("bonus_87", {bus60.tens, bus60.ones}, 8'h87);
    bus60.add_ones = 4'd8; step(1);
    check_val("bonus_95", {bus60.tens, bus60.ones}, 8'h95);
    bus60.add_ones = 4'd7; step(1);
    check_val("bonus_sat99", {bus60.tens, bus60.ones}, 8'h99);
    bus60.add_time = 1'b0;

    // Tick and bonus in the same cycle at 18
    bus60.start_level = 1'b1; bus60.enable_timer = 1'b1;
    step(1);
    bus60.start_level = 1'b0;
    step(168);
    check_val("reach18", {bus60.tens, bus60.ones}, 8'h18);
    step(3);
    bus60.add_time = 1'b1; bus60.add_ones = 4'd5;
    step(1);
    bus60.add_time = 1'b0;
    check_val("tick_bonus_22", {bus60.tens, bus60.ones}, 8'h22);
    check_val("tick_bonus_osec", bus60.one_sec, 1);

    // Out-of-range bonus ignored
    bus60.enable_timer = 1'b0;
    bus60.add_time = 1'b1; bus60.add_ones = 4'd12;
    step(1);
    bus60.add_time = 1'b0;
    check_val("bonus_bad_digit", {bus60.tens, bus60.ones}, 8'h22);

    // Expired level cannot be revived
    bus11.add_time = 1'b1; bus11.add_ones = 4'd3;
    step(1);
    bus11.add_time = 1'b0;
    check_val("bonus_at00", {bus11.tens, bus11.ones}, 8'h00);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
